// File: rtl/sisd_pkg.sv
// Shared widths and types for the SISD core front end.
package sisd_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the instruction-memory channel, the decode stream and the redirect inputs.
interface fetch_unit_if;

    logic                         imem_req_valid;
    logic                         imem_req_ready;
    logic [sisd_pkg::ADDR_W-1:0]  imem_addr;
    logic                         imem_rsp_valid;
    logic [sisd_pkg::INSTR_W-1:0] imem_rsp_data;
    logic                         instr_valid;
    logic                         instr_ready;
    logic [sisd_pkg::INSTR_W-1:0] instruction;
    logic [sisd_pkg::ADDR_W-1:0]  instr_pc;
    logic                         jump_en;
    logic [sisd_pkg::ADDR_W-1:0]  jump_address;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instruction, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               jump_en, jump_address
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instruction, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               jump_en, jump_address
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, word} entries; flush wins over a same-cycle push.
module fetch_fifo
    import sisd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush, doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i && !rst) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues in-order memory reads, buffers words for decode, handles redirects.
module fetch_unit
    import sisd_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0,
    parameter int                DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] respPc_q, respPc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  dropCnt_q, dropCnt_d;
    logic [CNT_W-1:0]  fifoCount;
    logic [CNT_W:0]    inUse;
    logic              fifoEmpty, fifoFull;
    logic              reqFire, rspFire, keepRsp, outFire, redirect;
    fetch_entry_t      pushEntry, headEntry;

    // Requests stop once in-flight plus buffered words would exceed the buffer.
    assign inUse              = {1'b0, outstanding_q} + {1'b0, fifoCount};
    assign bus.imem_req_valid = !rst && !fifoFull && (inUse < (CNT_W + 1)'(DEPTH));
    assign bus.imem_addr      = pc_q;

    assign reqFire  = bus.imem_req_valid && bus.imem_req_ready;
    assign rspFire  = bus.imem_rsp_valid;
    assign keepRsp  = rspFire && (dropCnt_q == '0);
    assign outFire  = bus.instr_valid && bus.instr_ready;
    assign redirect = bus.jump_en && outFire;

    assign pushEntry.pc   = respPc_q;
    assign pushEntry.data = bus.imem_rsp_data;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (keepRsp),
        .pop_i   (outFire),
        .flush_i (redirect),
        .wdata_i (pushEntry),
        .rdata_o (headEntry),
        .count_o (fifoCount),
        .empty_o (fifoEmpty),
        .full_o  (fifoFull)
    );

    assign bus.instr_valid = !fifoEmpty;
    assign bus.instruction = fifoEmpty ? NOP_INSTR : headEntry.data;
    assign bus.instr_pc    = fifoEmpty ? '0 : headEntry.pc;

    // On a redirect everything still in flight, including this cycle's request, is wrong-path.
    always_comb begin
        pc_d          = pc_q;
        respPc_d      = respPc_q;
        outstanding_d = outstanding_q + CNT_W'(reqFire) - CNT_W'(rspFire);
        dropCnt_d     = dropCnt_q;
        if (redirect) begin
            pc_d      = bus.jump_address;
            respPc_d  = bus.jump_address;
            dropCnt_d = outstanding_d;
        end else begin
            if (reqFire) pc_d = pc_q + 32'd1;
            if (keepRsp) respPc_d = respPc_q + 32'd1;
            if (rspFire && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            respPc_q      <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            respPc_q      <= respPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: program-order PC model, in-order memory model, directed and random phases.
module tb_fetch_unit;
    import sisd_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h10;
    localparam int          DEPTH    = 4;

    logic clk = 1'b0;
    logic rst;
    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int fireCnt = 0;
    bit memRandom = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          t;
    } memReq_t;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic jmp, input logic [31:0] target);
        @(posedge clk);
        #1;
        bus.instr_ready  = ready;
        bus.jump_en      = jmp;
        bus.jump_address = target;
    endtask

    task automatic waitFires(input int n, input int budget);
        int start;
        int c;
        start = fireCnt;
        c = 0;
        while ((fireCnt - start) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if ((fireCnt - start) < n) begin
            errors++;
            $display("[TB] FAIL watchdog fires=%0d required=%0d", fireCnt - start, n);
        end
    endtask

    // In-order memory: captures fired requests, answers no earlier than the following cycle.
    initial begin
        memReq_t pend[$];
        int      cyc;
        cyc = 0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.imem_req_valid && bus.imem_req_ready)
                pend.push_back('{addr: bus.imem_addr, t: cyc});
            @(posedge clk);
            cyc++;
            #2;
            if (rst) begin
                pend.delete();
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
                bus.imem_req_ready = 1'b0;
            end else begin
                bus.imem_req_ready = memRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (pend.size() > 0 && cyc >= pend[0].t + 1 &&
                    (!memRandom || $urandom_range(0, 2) != 0)) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = memWord(pend[0].addr);
                    void'(pend.pop_front());
                end else begin
                    bus.imem_rsp_valid = 1'b0;
                    bus.imem_rsp_data  = $urandom;
                end
            end
        end
    end

    // Monitor: the correct-path stream is RESET_PC, then +1 per word, or the target after a taken jump.
    initial begin
        logic [31:0] expQ[$];
        logic [31:0] e;
        logic [31:0] prevInstr, prevPc;
        bit          prevHold;
        prevHold  = 1'b0;
        prevInstr = '0;
        prevPc    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                expQ.delete();
                expQ.push_back(RESET_PC);
                prevHold = 1'b0;
            end else begin
                if (!bus.instr_valid) begin
                    checkOutput("bubble_instruction", bus.instruction, NOP_INSTR);
                    checkOutput("bubble_pc", bus.instr_pc, 32'h0);
                end
                if (prevHold) begin
                    checkOutput("stall_valid", 32'(bus.instr_valid), 32'h1);
                    checkOutput("stall_instruction", bus.instruction, prevInstr);
                    checkOutput("stall_pc", bus.instr_pc, prevPc);
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    fireCnt++;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL scoreboard_empty actual_pc=%h required=none", bus.instr_pc);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("instr_pc", bus.instr_pc, e);
                        checkOutput("instruction", bus.instruction, memWord(e));
                        expQ.push_back(bus.jump_en ? bus.jump_address : e + 32'd1);
                    end
                end
                prevHold  = bus.instr_valid && !bus.instr_ready;
                prevInstr = bus.instruction;
                prevPc    = bus.instr_pc;
            end
        end
    end

    initial begin
        int c;
        rst              = 1'b1;
        bus.instr_ready  = 1'b0;
        bus.jump_en      = 1'b0;
        bus.jump_address = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("rst_instruction", bus.instruction, 32'h0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);

        // Release reset with always-ready L=1 memory
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checkOutput("first_req_valid", 32'(bus.imem_req_valid), 32'h1);
        checkOutput("first_req_addr", bus.imem_addr, RESET_PC);
        @(negedge clk);
        checkOutput("cycle2_instr_valid", 32'(bus.instr_valid), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("stream_valid", 32'(bus.instr_valid), 32'h1);
            checkOutput("stream_pc", bus.instr_pc, RESET_PC + 32'(i));
        end

        // Long stall fills the buffer and stops requests
        applyStimulus(1'b0, 1'b0, '0);
        repeat (10) @(negedge clk);
        checkOutput("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, '0);
        waitFires(6, 50);

        // Redirect with requests in flight
        applyStimulus(1'b1, 1'b1, 32'h40);
        applyStimulus(1'b1, 1'b0, '0);
        c = 0;
        while (!bus.instr_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        checkOutput("redirect_target_pc", bus.instr_pc, 32'h41);
        waitFires(4, 50);

        // Jump while decode is stalled is ignored
        applyStimulus(1'b0, 1'b1, 32'h80);
        applyStimulus(1'b0, 1'b1, 32'h90);
        applyStimulus(1'b1, 1'b0, '0);
        waitFires(5, 50);

        // Wrap around the top of the address space
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 1'b0, '0);
        waitFires(6, 50);

        // Random traffic, random memory latency and backpressure
        memRandom = 1'b1;
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                       : 32'($urandom));
        end
        applyStimulus(1'b1, 1'b0, '0);
        waitFires(8, 300);

        // Reset during a stall with a full buffer
        memRandom = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        checkOutput("post_rst_instruction", bus.instruction, 32'h0);
        checkOutput("post_rst_req_valid", 32'(bus.imem_req_valid), 32'h1);
        checkOutput("post_rst_req_addr", bus.imem_addr, RESET_PC);
        applyStimulus(1'b1, 1'b0, '0);
        waitFires(6, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=expired required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
